// File: rtl/rumble_pkg.sv
// Shared types and helpers for the cartridge rumble driver.
package rumble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_LEVEL  = 1'b1;

    // Full-scale intensity for a given level width.
    function automatic int unsigned level_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/rumble_driver_if.sv
// Core-side request and cart-side motor/strobe signals of the rumble driver.
interface rumble_driver_if #(
    parameter int unsigned LEVEL_W = 2
);
    logic               rumble_en;
    logic               rumbling;
    logic               mode;
    logic [LEVEL_W-1:0] level;
    logic               cart_wr;
    logic               cart_rumble;
    logic               busy;
    logic [LEVEL_W-1:0] level_acc;

    modport master (
        output rumble_en, rumbling, mode, level,
        input  cart_wr, cart_rumble, busy, level_acc
    );

    modport slave (
        input  rumble_en, rumbling, mode, level,
        output cart_wr, cart_rumble, busy, level_acc
    );
endinterface

// File: rtl/rumble_level_accum.sv
// Error-diffusion accumulator turning an intensity level into a per-slot motor bit.
module rumble_level_accum
    import rumble_pkg::*;
#(
    parameter int unsigned LEVEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               step,
    input  logic [LEVEL_W-1:0] level,
    output logic               bit_c,
    output logic [LEVEL_W-1:0] acc
);
    localparam int unsigned     SUM_W = LEVEL_W + 1;
    localparam logic [SUM_W-1:0] MAX  = SUM_W'(level_max(LEVEL_W));

    logic [LEVEL_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0]   base_c, sum_c;

    // Clear takes effect before the step so a fresh run starts from zero.
    always_comb begin
        base_c = clear ? '0 : {1'b0, acc_q};
        sum_c  = base_c + {1'b0, level};
        bit_c  = (sum_c >= MAX);
        acc_d  = acc_q;
        if (step) begin
            acc_d = bit_c ? LEVEL_W'(sum_c - MAX) : LEVEL_W'(sum_c);
        end else if (clear) begin
            acc_d = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/rumble_driver.sv
// Slot-based rumble motor driver: toggle or level (error-diffused) modes, stop write on release.
module rumble_driver
    import rumble_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 9,
    parameter int unsigned WR_CYCLES     = 9,
    parameter int unsigned PERIOD_CYCLES = 85192,
    parameter int unsigned LEVEL_W       = 2
) (
    input  logic            clk,
    input  logic            reset,
    rumble_driver_if.slave  bus
);
    localparam int unsigned      CNT_W      = $clog2(PERIOD_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(SETUP_CYCLES + WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stop_q, stop_d;
    logic               cart_wr_q, cart_wr_d;
    logic               cart_rumble_q, cart_rumble_d;
    logic               busy_q, busy_d;

    logic               active_c;
    logic               start_norm_c, start_stop_c;
    logic               new_bit_c;
    logic               acc_clear_c, acc_step_c;
    logic               acc_bit_c;
    logic [LEVEL_W-1:0] acc_val;

    assign active_c = bus.rumble_en & bus.rumbling;

    rumble_level_accum #(.LEVEL_W(LEVEL_W)) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (acc_clear_c),
        .step  (acc_step_c),
        .level (bus.level),
        .bit_c (acc_bit_c),
        .acc   (acc_val)
    );

    // Next-state, slot counter and motor-bit selection.
    always_comb begin
        state_d       = state_q;
        stop_d        = stop_q;
        cart_rumble_d = cart_rumble_q;
        start_norm_c  = 1'b0;
        start_stop_c  = 1'b0;
        new_bit_c     = (bus.mode == MODE_LEVEL) ? acc_bit_c : ~cart_rumble_q;

        unique case (state_q)
            ST_IDLE: begin
                if (active_c) start_norm_c = 1'b1;
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (cnt_q == WRITE_LAST) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == SLOT_LAST) begin
                    if (stop_q)             state_d = ST_IDLE;
                    else if (active_c)      start_norm_c = 1'b1;
                    else if (cart_rumble_q) start_stop_c = 1'b1;
                    else                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_norm_c || start_stop_c) begin
            state_d       = ST_SETUP;
            stop_d        = start_stop_c;
            cart_rumble_d = start_stop_c ? 1'b0 : new_bit_c;
        end else if (state_d == ST_IDLE) begin
            stop_d = 1'b0;
        end

        acc_clear_c = start_stop_c | (start_norm_c && state_q == ST_IDLE);
        acc_step_c  = start_norm_c && (bus.mode == MODE_LEVEL);

        cnt_d     = (start_norm_c || start_stop_c || state_d == ST_IDLE)
                    ? '0 : cnt_q + CNT_W'(1);
        cart_wr_d = (state_d != ST_WRITE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            stop_q        <= 1'b0;
            cart_wr_q     <= 1'b1;
            cart_rumble_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stop_q        <= stop_d;
            cart_wr_q     <= cart_wr_d;
            cart_rumble_q <= cart_rumble_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cart_wr     = cart_wr_q;
    assign bus.cart_rumble = cart_rumble_q;
    assign bus.busy        = busy_q;
    assign bus.level_acc   = acc_val;
endmodule

// File: tb/tb_rumble_driver.sv
// Directed bench for rumble_driver with SETUP=2, WR=3, PERIOD=10, LEVEL_W=2.
module tb_rumble_driver;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    rumble_driver_if #(.LEVEL_W(2)) bus ();

    rumble_driver #(
        .SETUP_CYCLES  (2),
        .WR_CYCLES     (3),
        .PERIOD_CYCLES (10),
        .LEVEL_W       (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One 10-cycle slot: strobe low in slot cycles 3..5, constant bit, busy high.
    task automatic run_slot(input logic eb, input int drop_at, input int chg_at,
                            input logic [1:0] chg_lvl, input string tag);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk({tag, " cart_wr"}, 8'(bus.cart_wr), 8'((k >= 3 && k <= 5) ? 0 : 1));
            chk({tag, " cart_rumble"}, 8'(bus.cart_rumble), 8'(eb));
            chk({tag, " busy"}, 8'(bus.busy), 8'd1);
            if (k == drop_at) bus.rumbling = 1'b0;
            if (k == chg_at)  bus.level = chg_lvl;
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, " cart_wr"}, 8'(bus.cart_wr), 8'd1);
            chk({tag, " cart_rumble"}, 8'(bus.cart_rumble), 8'd0);
            chk({tag, " busy"}, 8'(bus.busy), 8'd0);
        end
    endtask

    initial begin
        logic [5:0] l1_seq;
        logic [5:0] l2_seq;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.rumble_en = 1'b0;
        bus.rumbling  = 1'b0;
        bus.mode      = 1'b0;
        bus.level     = 2'd0;
        l1_seq = 6'b100100;
        l2_seq = 6'b110110;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst cart_wr", 8'(bus.cart_wr), 8'd1);
        chk("rst cart_rumble", 8'(bus.cart_rumble), 8'd0);
        chk("rst busy", 8'(bus.busy), 8'd0);
        chk("rst acc", 8'(bus.level_acc), 8'd0);
        reset = 1'b0;
        idle_check(2, "post-rst idle");

        // Toggle mode: 1,0,1,0 then stop-off from a slot with bit 1
        bus.mode = 1'b0; bus.rumble_en = 1'b1; bus.rumbling = 1'b1;
        run_slot(1'b1, 0, 0, 2'd0, "tog s1");
        run_slot(1'b0, 0, 0, 2'd0, "tog s2");
        run_slot(1'b1, 0, 0, 2'd0, "tog s3");
        run_slot(1'b0, 0, 0, 2'd0, "tog s4");
        run_slot(1'b1, 4, 0, 2'd0, "stopoff drop");
        run_slot(1'b0, 0, 0, 2'd0, "stopoff final");
        idle_check(5, "stopoff idle");

        // Stop-quiet: drop while bit is 0, no extra write
        bus.rumbling = 1'b1;
        run_slot(1'b1, 0, 0, 2'd0, "quiet s1");
        run_slot(1'b0, 4, 0, 2'd0, "quiet s2");
        idle_check(20, "quiet idle");

        // Gate: no enable, no activity
        bus.rumble_en = 1'b0; bus.rumbling = 1'b1;
        idle_check(50, "gate");

        // Level sweep; acc returns to 0 after each 6-slot run
        bus.rumble_en = 1'b1; bus.mode = 1'b1; bus.level = 2'd1;
        for (int s = 0; s < 6; s++)
            run_slot(l1_seq[s], 0, (s == 5) ? 5 : 0, 2'd2, $sformatf("lvl1 s%0d", s));
        for (int s = 0; s < 6; s++)
            run_slot(l2_seq[s], 0, (s == 5) ? 5 : 0, 2'd3, $sformatf("lvl2 s%0d", s));
        for (int s = 0; s < 6; s++)
            run_slot(1'b1, 0, (s == 5) ? 5 : 0, 2'd0, $sformatf("lvl3 s%0d", s));
        for (int s = 0; s < 6; s++)
            run_slot(1'b0, 0, (s == 5) ? 5 : 0, 2'd1, $sformatf("lvl0 s%0d", s));

        // Build acc=2, then slot with bit 1 at level 3 (acc stays 2)
        run_slot(1'b0, 0, 0, 2'd0, "pre-rst a");
        run_slot(1'b0, 0, 5, 2'd3, "pre-rst b");
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("mid cart_wr", 8'(bus.cart_wr), 8'((k >= 3) ? 0 : 1));
            chk("mid cart_rumble", 8'(bus.cart_rumble), 8'd1);
            chk("mid acc", 8'(bus.level_acc), 8'd2);
        end
        reset = 1'b1;
        bus.level = 2'd2;
        @(negedge clk);
        chk("rst-wr cart_wr", 8'(bus.cart_wr), 8'd1);
        chk("rst-wr cart_rumble", 8'(bus.cart_rumble), 8'd0);
        chk("rst-wr busy", 8'(bus.busy), 8'd0);
        chk("rst-wr acc", 8'(bus.level_acc), 8'd0);
        @(negedge clk);
        chk("rst-hold busy", 8'(bus.busy), 8'd0);
        reset = 1'b0;

        // Fresh start from acc=0 at level 2: bits 0 then 1, then stop slot
        run_slot(1'b0, 0, 0, 2'd0, "fresh s1");
        chk("fresh acc", 8'(bus.level_acc), 8'd2);
        run_slot(1'b1, 4, 0, 2'd0, "fresh s2");
        run_slot(1'b0, 0, 0, 2'd0, "fresh stop");
        idle_check(3, "final idle");
        chk("final acc", 8'(bus.level_acc), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
